keypad_scanner: RTL and testbench



---
 rtl/keypad_scanner.sv | 183 ++++++++++++++++++
 tb/tb_keypad_scanner.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: drives one column low at a time, freezes on a press,
// debounces press and release, and reports a stable key code with a press strobe.
module keypad_scanner #(
  parameter int NROWS           = 4,
  parameter int NCOLS           = 4,
  parameter int SETTLE_CYCLES   = 16,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [NROWS-1:0]                 kpr,
  output logic [NCOLS-1:0]                 kpc,
  output logic [$clog2(NROWS*NCOLS)-1:0]   key_code,
  output logic                             key_valid,
  output logic                             key_pressed,
  output logic                             multi_key
);

  localparam int KW   = $clog2(NROWS*NCOLS);
  localparam int CW   = $clog2(NCOLS);
  localparam int RW   = $clog2(NROWS);
  localparam int MAXC = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ? SETTLE_CYCLES : DEBOUNCE_CYCLES;
  localparam int CNTW = $clog2(MAXC + 1);

  localparam logic [CNTW-1:0] SETTLE_LAST = CNTW'(SETTLE_CYCLES - 1);
  localparam logic [CNTW-1:0] DB_LAST     = CNTW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]   COL_LAST    = CW'(NCOLS - 1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     col_q, col_d, col_next;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [NROWS-1:0]  pat_q, pat_d;
  logic [NROWS-1:0]  sync1_q, rs_q;
  logic [NCOLS-1:0]  kpc_q;
  logic [KW-1:0]     code_q, code_d, accept_code;
  logic              valid_q, valid_d;
  logic              pressed_q, pressed_d;
  logic              multi_q, multi_d;
  logic [RW-1:0]     low_row;
  logic [3:0]        nzero;
  logic              rs_idle;

  function automatic logic [NCOLS-1:0] col_to_kpc(input logic [CW-1:0] c);
    logic [NCOLS-1:0] m;
    m = '1;
    m[NCOLS-1-int'(c)] = 1'b0;
    return m;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '1;
      rs_q    <= '1;
    end else begin
      sync1_q <= kpr;
      rs_q    <= sync1_q;
    end
  end

  assign rs_idle  = (rs_q == '1);
  assign col_next = (col_q == COL_LAST) ? '0 : col_q + 1'b1;

  // Lowest closed row wins the code; more than one closed row flags multi_key.
  always_comb begin
    low_row = '0;
    nzero   = '0;
    for (int r = NROWS - 1; r >= 0; r--) begin
      if (!pat_q[r]) low_row = RW'(r);
    end
    for (int r = 0; r < NROWS; r++) begin
      nzero = nzero + {3'b000, ~pat_q[r]};
    end
    accept_code = KW'(int'(low_row) * NCOLS + int'(col_q));
  end

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    cnt_d     = cnt_q;
    pat_d     = pat_q;
    code_d    = code_q;
    valid_d   = valid_q;
    multi_d   = multi_q;
    pressed_d = 1'b0;
    case (state_q)
      SCAN: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d = '0;
          if (rs_idle) begin
            col_d = col_next;
          end else begin
            pat_d   = rs_q;
            state_d = PRESS_DB;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESS_DB: begin
        if (rs_q == pat_q) begin
          if (cnt_q == DB_LAST) begin
            state_d   = HELD;
            cnt_d     = '0;
            code_d    = accept_code;
            multi_d   = (nzero > 4'd1);
            valid_d   = 1'b1;
            pressed_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          state_d = SCAN;
          cnt_d   = '0;
        end
      end
      HELD: begin
        if (rs_idle) begin
          state_d = REL_DB;
          cnt_d   = '0;
        end
      end
      REL_DB: begin
        if (rs_idle) begin
          if (cnt_q == DB_LAST) begin
            state_d = SCAN;
            cnt_d   = '0;
            valid_d = 1'b0;
            multi_d = 1'b0;
            col_d   = col_next;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          state_d = HELD;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = SCAN;
        col_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= SCAN;
      col_q     <= '0;
      cnt_q     <= '0;
      pat_q     <= '1;
      kpc_q     <= col_to_kpc('0);
      code_q    <= '0;
      valid_q   <= 1'b0;
      pressed_q <= 1'b0;
      multi_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      cnt_q     <= cnt_d;
      pat_q     <= pat_d;
      kpc_q     <= col_to_kpc(col_d);
      code_q    <= code_d;
      valid_q   <= valid_d;
      pressed_q <= pressed_d;
      multi_q   <= multi_d;
    end
  end

  assign kpc         = kpc_q;
  assign key_code    = code_q;
  assign key_valid   = valid_q;
  assign key_pressed = pressed_q;
  assign multi_key   = multi_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a 4x4 instance with a keypad model, plus a
// 2x8 instance for the wide-column key code.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;

  logic [3:0] keys_a [4];
  logic [3:0] kpr_a;
  logic [3:0] kpc_a;
  logic [3:0] code_a;
  logic       valid_a, pressed_a, multi_a;

  logic [7:0] keys_b [2];
  logic [1:0] kpr_b;
  logic [7:0] kpc_b;
  logic [3:0] code_b;
  logic       valid_b, pressed_b, multi_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  keypad_scanner #(.NROWS(4), .NCOLS(4), .SETTLE_CYCLES(4), .DEBOUNCE_CYCLES(8)) dut_a (
    .clk(clk), .reset_n(reset_n), .kpr(kpr_a), .kpc(kpc_a), .key_code(code_a),
    .key_valid(valid_a), .key_pressed(pressed_a), .multi_key(multi_a)
  );

  keypad_scanner #(.NROWS(2), .NCOLS(8), .SETTLE_CYCLES(4), .DEBOUNCE_CYCLES(8)) dut_b (
    .clk(clk), .reset_n(reset_n), .kpr(kpr_b), .kpc(kpc_b), .key_code(code_b),
    .key_valid(valid_b), .key_pressed(pressed_b), .multi_key(multi_b)
  );

  // Closed switch (r,c) pulls row r low while column c is driven low.
  always_comb begin
    kpr_a = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys_a[r][c] && !kpc_a[3-c]) kpr_a[r] = 1'b0;
  end

  always_comb begin
    kpr_b = '1;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 8; c++)
        if (keys_b[r][c] && !kpc_b[7-c]) kpr_b[r] = 1'b0;
  end

  task automatic wait_kpc_a(input logic [3:0] v, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (kpc_a === v) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_pressed_a(output bit ok, output int n);
    ok = 1'b0;
    n  = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      n++;
      if (pressed_a === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_release_a(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n++;
      if (valid_a === 1'b0) break;
    end
  endtask

  task automatic test_reset();
    for (int r = 0; r < 4; r++) keys_a[r] = '0;
    for (int r = 0; r < 2; r++) keys_b[r] = '0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (kpc_a !== 4'b0111) begin errors++; $display("FAIL reset_kpc: got %b want 0111", kpc_a); end
    checks++; if (kpc_b !== 8'b01111111) begin errors++; $display("FAIL reset_kpc_b: got %b want 01111111", kpc_b); end
    checks++; if ({code_a, valid_a, pressed_a, multi_a} !== 7'd0) begin
      errors++; $display("FAIL reset_outputs: code=%0d valid=%b pressed=%b multi=%b want all 0", code_a, valid_a, pressed_a, multi_a);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_scan();
    bit         activity;
    logic [3:0] exp;
    activity = 1'b0;
    for (int i = 0; i < 17; i++) begin
      exp = 4'b1111;
      exp[3 - (i / 4) % 4] = 1'b0;
      checks++; if (kpc_a !== exp) begin errors++; $display("FAIL scan_kpc[%0d]: got %b want %b", i, kpc_a, exp); end
      if (valid_a !== 1'b0 || pressed_a !== 1'b0) activity = 1'b1;
      @(negedge clk);
    end
    checks++; if (activity) begin errors++; $display("FAIL scan_idle_outputs: saw valid/pressed high, want 0"); end
  endtask

  task automatic test_press();
    bit ok;
    int n, pulses;
    keys_a[2][1] = 1'b1;
    wait_kpc_a(4'b1011, ok);
    checks++; if (!ok) begin errors++; $display("FAIL press_col_timeout: kpc=%b never reached 1011", kpc_a); end
    wait_pressed_a(ok, n);
    checks++; if (!ok || n != 12) begin errors++; $display("FAIL press_latency: ok=%b cycles=%0d want 12", ok, n); end
    checks++; if (code_a !== 4'd9) begin errors++; $display("FAIL press_code: got %0d want 9", code_a); end
    checks++; if (valid_a !== 1'b1 || multi_a !== 1'b0) begin errors++; $display("FAIL press_flags: valid=%b multi=%b want 1 0", valid_a, multi_a); end
    @(negedge clk);
    checks++; if (pressed_a !== 1'b0) begin errors++; $display("FAIL press_strobe_width: got %b want 0", pressed_a); end
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pressed_a === 1'b1) pulses++;
    end
    checks++; if (pulses != 0 || kpc_a !== 4'b1011 || valid_a !== 1'b1) begin
      errors++; $display("FAIL press_hold: pulses=%0d kpc=%b valid=%b want 0 1011 1", pulses, kpc_a, valid_a);
    end
    keys_a[2][1] = 1'b0;
    wait_release_a(n);
    checks++; if (n != 11) begin errors++; $display("FAIL release_latency: cycles=%0d want 11", n); end
    checks++; if (kpc_a !== 4'b1101 || code_a !== 4'd9) begin errors++; $display("FAIL release_state: kpc=%b code=%0d want 1101 9", kpc_a, code_a); end
  endtask

  task automatic test_bounce();
    bit ok;
    int first, pulses, n;
    logic [3:0] code_at;
    wait_kpc_a(4'b1110, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bounce_col_timeout: kpc=%b never reached 1110", kpc_a); end
    keys_a[0][3] = 1'b1;
    first = -1; pulses = 0; code_at = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 3) keys_a[0][3] = 1'b0;
      if (k == 5) keys_a[0][3] = 1'b1;
      if (pressed_a === 1'b1) begin
        pulses++;
        if (first < 0) begin first = k; code_at = code_a; end
      end
    end
    checks++; if (pulses != 1 || first != 18) begin errors++; $display("FAIL bounce_strobe: pulses=%0d at=%0d want 1 at 18", pulses, first); end
    checks++; if (code_at !== 4'd3) begin errors++; $display("FAIL bounce_code: got %0d want 3", code_at); end
    keys_a[0][3] = 1'b0;
    wait_release_a(n);
  endtask

  task automatic test_multi();
    bit ok;
    int n;
    keys_a[1][0] = 1'b1;
    keys_a[3][0] = 1'b1;
    wait_pressed_a(ok, n);
    checks++; if (!ok) begin errors++; $display("FAIL multi_timeout: no key_pressed within %0d cycles", n); end
    checks++; if (code_a !== 4'd4 || multi_a !== 1'b1 || kpc_a !== 4'b0111) begin
      errors++; $display("FAIL multi_accept: code=%0d multi=%b kpc=%b want 4 1 0111", code_a, multi_a, kpc_a);
    end
    keys_a[1][0] = 1'b0;
    keys_a[3][0] = 1'b0;
    wait_release_a(n);
    checks++; if (n != 11) begin errors++; $display("FAIL multi_release_latency: cycles=%0d want 11", n); end
    checks++; if (multi_a !== 1'b0 || kpc_a !== 4'b1011) begin errors++; $display("FAIL multi_release_state: multi=%b kpc=%b want 0 1011", multi_a, kpc_a); end
  endtask

  task automatic test_release_glitch();
    bit ok;
    int n, drops, pulses;
    keys_a[2][1] = 1'b1;
    wait_pressed_a(ok, n);
    checks++; if (!ok || code_a !== 4'd9) begin errors++; $display("FAIL glitch_accept: ok=%b code=%0d want 1 9", ok, code_a); end
    drops = 0; pulses = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (valid_a !== 1'b1) drops++;
      if (pressed_a === 1'b1) pulses++;
      if (k == 3) keys_a[2][1] = 1'b0;
      if (k == 8) keys_a[2][1] = 1'b1;
    end
    checks++; if (drops != 0 || pulses != 0) begin errors++; $display("FAIL glitch_hold: valid_drops=%0d extra_strobes=%0d want 0 0", drops, pulses); end
    checks++; if (kpc_a !== 4'b1011) begin errors++; $display("FAIL glitch_column: got %b want 1011", kpc_a); end
    keys_a[2][1] = 1'b0;
    wait_release_a(n);
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n;
    keys_a[2][1] = 1'b1;
    wait_kpc_a(4'b1011, ok);
    repeat (6) @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    checks++; if (kpc_a !== 4'b0111 || {code_a, valid_a, pressed_a, multi_a} !== 7'd0) begin
      errors++; $display("FAIL reset_in_press_db: kpc=%b code=%0d valid=%b pressed=%b multi=%b want 0111 and 0s", kpc_a, code_a, valid_a, pressed_a, multi_a);
    end
    keys_a[2][1] = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (kpc_a !== 4'b0111) begin errors++; $display("FAIL restart_col0: got %b want 0111", kpc_a); end
    @(negedge clk);
    checks++; if (kpc_a !== 4'b1011) begin errors++; $display("FAIL restart_col1: got %b want 1011", kpc_a); end
    keys_a[2][1] = 1'b1;
    wait_pressed_a(ok, n);
    checks++; if (!ok || valid_a !== 1'b1) begin errors++; $display("FAIL held_before_reset: ok=%b valid=%b want 1 1", ok, valid_a); end
    repeat (3) @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    checks++; if (kpc_a !== 4'b0111 || {code_a, valid_a, pressed_a, multi_a} !== 7'd0) begin
      errors++; $display("FAIL reset_in_held: kpc=%b code=%0d valid=%b pressed=%b multi=%b want 0111 and 0s", kpc_a, code_a, valid_a, pressed_a, multi_a);
    end
    keys_a[2][1] = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_wide();
    bit ok;
    ok = 1'b0;
    keys_b[1][6] = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (pressed_b === 1'b1) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL wide_timeout: no key_pressed on 2x8 instance"); end
    checks++; if (code_b !== 4'd14 || valid_b !== 1'b1 || multi_b !== 1'b0) begin
      errors++; $display("FAIL wide_accept: code=%0d valid=%b multi=%b want 14 1 0", code_b, valid_b, multi_b);
    end
    checks++; if (kpc_b !== 8'b11111101) begin errors++; $display("FAIL wide_kpc: got %b want 11111101", kpc_b); end
    keys_b[1][6] = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_press();
    test_bounce();
    test_multi();
    test_release_glitch();
    test_reset_mid();
    test_wide();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
